fetch_ifid: RTL and testbench
=============================

Name: fetch_ifid

Overview:
Fetch-side counterpart of the hazard unit. It consumes the hazard unit's PC_En/IF_ID_En stall outputs and produces the valid_inst, rst_reg and IF/ID.RS1/RS2 signals that the hazard unit reads. It owns the PC register, drives the instruction-memory read address, and holds the IF/ID pipeline register, including its valid bit. It also handles branch/jump redirect with a flush of IF/ID.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INST, 32'h0000_0013, encoding held in IF/ID when invalid (addi x0,x0,0).

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_pc_en  in  1  PC update enable (from hazard PC_En)
i_if_id_en  in  1  IF/ID load enable (from hazard IF_ID_En)
i_redirect  in  1  taken branch/jump resolved downstream
i_redirect_pc  in  32  redirect target
o_imem_raddr  out  32  instruction memory address (= PC, combinational read)
i_imem_rdata  in  32  instruction word for o_imem_raddr, same cycle
o_if_id_pc  out  32  PC of instruction in IF/ID
o_if_id_inst  out  32  instruction in IF/ID
o_if_id_rs1  out  5  o_if_id_inst[19:15]
o_if_id_rs2  out  5  o_if_id_inst[24:20]
o_valid_inst  out  1  IF/ID holds a real instruction
o_rst_reg  out  1  registered "not yet running" flag, forces hazard stall

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst. There is no async path.
- State machine with states S_RESET, S_BOOT and S_RUN:
  - i_rst=1 → S_RESET at the next edge, from any state (reset mid-operation included).
  - S_RESET with i_rst=0 → S_BOOT.
  - S_BOOT → S_RUN unconditionally.
- o_rst_reg = (state != S_RUN). It is registered and has no combinational path from i_rst.
- On reset, registers load as follows:
  - pc = RESET_ADDR
  - if_id_valid = 0, if_id_inst = NOP_INST, if_id_pc = RESET_ADDR
  - i_redirect, i_pc_en and i_if_id_en are ignored.
- In S_BOOT, pc and IF/ID hold. The first fetch capture occurs in the first S_RUN cycle, when the enables are high.
- In S_RUN, updates follow this priority, highest first:
  1. i_redirect=1: pc ← {i_redirect_pc[31:2],2'b00}; if_id_valid ← 0; if_id_inst ← NOP_INST. This overrides stall (both enables are ignored).
  2. Otherwise the enables act independently:
     - i_pc_en=1: pc ← pc+4, with 32-bit wrap (32'hFFFF_FFFC → 0).
     - i_if_id_en=1: if_id_inst ← i_imem_rdata; if_id_pc ← pc; if_id_valid ← 1.
     - A disabled enable holds its register.
     - If i_pc_en=1 and i_if_id_en=0, the fetched word is dropped. This is legal but never driven by the hazard unit.
- o_imem_raddr = pc, combinational.
- o_valid_inst = if_id_valid.
- o_if_id_rs1 and o_if_id_rs2 are sliced from the IF/ID register even when invalid. NOP_INST gives 0/0, so hazards are also masked by the consumer through valid_inst.
- Latency: an instruction at address A is visible on o_if_id_* one cycle after pc==A with both enables high.
- A redirect costs one bubble: the cycle after the redirect shows o_valid_inst=0, and the target is fetched that same cycle.

Optional Feature:
FETCH_PERF_EN:
- When defined, the block adds three 32-bit outputs: o_fetch_cnt, o_stall_cnt and o_flush_cnt.
- All three reset to 0 and wrap on overflow.
- Increment rules:
  - o_fetch_cnt: +1 on each IF/ID capture.
  - o_stall_cnt: +1 per S_RUN cycle with i_if_id_en=0 and i_redirect=0.
  - o_flush_cnt: +1 per accepted redirect.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (S_RESET, S_BOOT, S_RUN)
  - RS1_LSB=15, RS2_LSB=20, REG_W=5, XLEN=32
  - default NOP encoding
- One natural sub-module, if_id_reg: the enable/flush register for {valid, pc, inst}.
- The PC logic and state machine stay in the top level.

Test Plan:
- Reset release: hold i_rst 3 cycles, then deassert with enables=1 → o_rst_reg=1 through the S_BOOT cycle, then 0; o_imem_raddr stays 0 until S_RUN; first capture gives o_if_id_pc=0, o_valid_inst=1.
- Sequential fetch: imem returns addr-indexed words, 4 run cycles → o_if_id_pc = 0,4,8,C in successive cycles; rs1/rs2 match inst[19:15]/[24:20] (e.g. 32'h00B50533 → rs1=10, rs2=11).
- Stall: enables low 2 cycles at pc=8 → o_imem_raddr holds 8, IF/ID holds pc=4 contents; resumes with pc=8 captured next.
- Redirect during stall: enables=0, i_redirect=1, target 32'h0000_0103 → pc=32'h100, o_valid_inst=0, o_if_id_inst=NOP; next cycle captures pc=0x100.
- Wrap and mid-run reset: pc=32'hFFFF_FFFC advances → 0; then pulse i_rst while running → next cycle pc=RESET_ADDR, valid=0, o_rst_reg=1.
- FETCH_PERF_EN: 5 fetches, 2 stall cycles, 1 redirect → counters read 5/2/1; reset clears all to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, field positions and the NOP encoding.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET,
    S_BOOT,
    S_RUN
  } state_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding {valid, pc, inst}; flush beats load, reset beats both.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST   = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] inst_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= RESET_ADDR;
      inst  <= NOP_INST;
    end else if (flush) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      inst  <= inst_in;
    end
  end

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage: PC register, boot state machine and IF/ID register with redirect flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_ifid
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST   = NOP_ENC
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pc_en,
  input  logic             i_if_id_en,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  output logic [XLEN-1:0]  o_imem_raddr,
  input  logic [XLEN-1:0]  i_imem_rdata,
  output logic [XLEN-1:0]  o_if_id_pc,
  output logic [XLEN-1:0]  o_if_id_inst,
  output logic [REG_W-1:0] o_if_id_rs1,
  output logic [REG_W-1:0] o_if_id_rs2,
  output logic             o_valid_inst,
  output logic             o_rst_reg
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0]  o_fetch_cnt,
  output logic [XLEN-1:0]  o_stall_cnt,
  output logic [XLEN-1:0]  o_flush_cnt
`endif
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            rst_reg;
  logic            running;
  logic            flush;
  logic            load;

  assign running = (state == S_RUN);
  assign flush   = running && i_redirect;
  assign load    = running && !i_redirect && i_if_id_en;

  // rst_reg tracks the state one-for-one so the hazard unit never sees i_rst directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_RESET;
      rst_reg <= 1'b1;
      pc      <= RESET_ADDR;
    end else begin
      case (state)
        S_RESET: begin
          state   <= S_BOOT;
          rst_reg <= 1'b1;
        end
        S_BOOT: begin
          state   <= S_RUN;
          rst_reg <= 1'b0;
        end
        S_RUN: begin
          rst_reg <= 1'b0;
          if (i_redirect) begin
            pc <= align_word(i_redirect_pc);
          end else if (i_pc_en) begin
            pc <= pc + 32'd4;
          end
        end
        default: begin
          state   <= S_RESET;
          rst_reg <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg #(
    .RESET_ADDR(RESET_ADDR),
    .NOP_INST  (NOP_INST)
  ) u_if_id (
    .clk    (i_clk),
    .rst    (i_rst),
    .flush  (flush),
    .load   (load),
    .pc_in  (pc),
    .inst_in(i_imem_rdata),
    .valid  (o_valid_inst),
    .pc     (o_if_id_pc),
    .inst   (o_if_id_inst)
  );

  assign o_imem_raddr = pc;
  assign o_rst_reg    = rst_reg;
  assign o_if_id_rs1  = o_if_id_inst[RS1_LSB +: REG_W];
  assign o_if_id_rs2  = o_if_id_inst[RS2_LSB +: REG_W];

`ifdef FETCH_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fetch_cnt <= '0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (load) o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (running && !i_redirect && !i_if_id_en) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (flush) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: directed boot/stall/redirect/wrap steps, then random traffic.
module tb_fetch_ifid;

   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        rst;
   logic        pcEn;
   logic        ifIdEn;
   logic        redirect;
   logic [31:0] redirectPc;
   logic [31:0] imemRaddr;
   logic [31:0] imemRdata;
   logic [31:0] ifIdPc;
   logic [31:0] ifIdInst;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        validInst;
   logic        rstReg;
`ifdef FETCH_PERF_EN
   logic [31:0] fetchCnt;
   logic [31:0] stallCnt;
   logic [31:0] flushCnt;
`endif

   int nChecks = 0;
   int nFails  = 0;

   // Reference model: cycles elapsed since reset release, plus the architectural fetch state.
   int unsigned mSinceReset;
   logic [31:0] mPc;
   logic [31:0] mIfPc;
   logic [31:0] mIfInst;
   logic        mValid;
   logic [31:0] mFetch;
   logic [31:0] mStall;
   logic [31:0] mFlush;

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Instruction memory contents are a fixed function of the address.
   function automatic logic [31:0] imemWord(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h00B5_0533;
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign imemRdata = imemWord(imemRaddr);

   fetch_ifid dut (
      .i_clk        (clock),
      .i_rst        (rst),
      .i_pc_en      (pcEn),
      .i_if_id_en   (ifIdEn),
      .i_redirect   (redirect),
      .i_redirect_pc(redirectPc),
      .o_imem_raddr (imemRaddr),
      .i_imem_rdata (imemRdata),
      .o_if_id_pc   (ifIdPc),
      .o_if_id_inst (ifIdInst),
      .o_if_id_rs1  (rs1),
      .o_if_id_rs2  (rs2),
      .o_valid_inst (validInst),
      .o_rst_reg    (rstReg)
`ifdef FETCH_PERF_EN
      ,
      .o_fetch_cnt  (fetchCnt),
      .o_stall_cnt  (stallCnt),
      .o_flush_cnt  (flushCnt)
`endif
   );

   // Single comparison point: counts the check and reports any disagreement.
   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Compares every DUT output against the reference model.
   task automatic checkOutput();
      logic [31:0] expRs1;
      logic [31:0] expRs2;
      expRs1 = {27'b0, mIfInst[19:15]};
      expRs2 = {27'b0, mIfInst[24:20]};
      checkVal("imem_raddr", imemRaddr, mPc);
      checkVal("if_id_pc", ifIdPc, mIfPc);
      checkVal("if_id_inst", ifIdInst, mIfInst);
      checkVal("if_id_rs1", {27'b0, rs1}, expRs1);
      checkVal("if_id_rs2", {27'b0, rs2}, expRs2);
      checkVal("valid_inst", {31'b0, validInst}, {31'b0, mValid});
      checkVal("rst_reg", {31'b0, rstReg}, {31'b0, (mSinceReset < 2)});
`ifdef FETCH_PERF_EN
      checkVal("fetch_cnt", fetchCnt, mFetch);
      checkVal("stall_cnt", stallCnt, mStall);
      checkVal("flush_cnt", flushCnt, mFlush);
`endif
   endtask

   // Drives one cycle of inputs, advances the model by one edge, then checks after the edge.
   task automatic applyStimulus(input logic r, input logic pe, input logic ie,
                                input logic rd, input logic [31:0] target);
      logic        running;
      logic [31:0] word;
      rst        = r;
      pcEn       = pe;
      ifIdEn     = ie;
      redirect   = rd;
      redirectPc = target;
      running    = (mSinceReset >= 2);
      word       = imemWord(mPc);
      if (r) begin
         mSinceReset = 0;
         mPc         = RESET_PC;
         mIfPc       = RESET_PC;
         mIfInst     = NOP_WORD;
         mValid      = 1'b0;
         mFetch      = '0;
         mStall      = '0;
         mFlush      = '0;
      end else begin
         if (running) begin
            if (rd) begin
               mPc     = {target[31:2], 2'b00};
               mValid  = 1'b0;
               mIfInst = NOP_WORD;
               mFlush  = mFlush + 1;
            end else begin
               if (ie) begin
                  mIfInst = word;
                  mIfPc   = mPc;
                  mValid  = 1'b1;
                  mFetch  = mFetch + 1;
               end else begin
                  mStall = mStall + 1;
               end
               if (pe) mPc = mPc + 32'd4;
            end
         end
         if (mSinceReset < 2) mSinceReset++;
      end
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   initial begin
      rst        = 1'b1;
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      redirect   = 1'b0;
      redirectPc = '0;
      mSinceReset = 0;
      mPc = '0; mIfPc = '0; mIfInst = NOP_WORD; mValid = 1'b0;
      mFetch = '0; mStall = '0; mFlush = '0;

      repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("reset_raddr", imemRaddr, 32'h0);
      checkVal("reset_rst_reg", {31'b0, rstReg}, 32'h1);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("boot_rst_reg", {31'b0, rstReg}, 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("run_rst_reg", {31'b0, rstReg}, 32'h0);
      checkVal("run_raddr", imemRaddr, 32'h0);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("first_pc", ifIdPc, 32'h0);
      checkVal("first_valid", {31'b0, validInst}, 32'h1);
      checkVal("first_rs1", {27'b0, rs1}, 32'd10);
      checkVal("first_rs2", {27'b0, rs2}, 32'd11);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("second_pc", ifIdPc, 32'h4);

      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkVal("stall_raddr", imemRaddr, 32'h8);
      checkVal("stall_if_pc", ifIdPc, 32'h4);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("resume_pc", ifIdPc, 32'h8);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("fourth_pc", ifIdPc, 32'hC);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
      checkVal("redir_raddr", imemRaddr, 32'h100);
      checkVal("redir_valid", {31'b0, validInst}, 32'h0);
      checkVal("redir_inst", ifIdInst, NOP_WORD);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("target_pc", ifIdPc, 32'h100);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checkVal("wrap_start", imemRaddr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkVal("wrap_raddr", imemRaddr, 32'h0);
      checkVal("wrap_if_pc", ifIdPc, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      checkVal("midrst_raddr", imemRaddr, RESET_PC);
      checkVal("midrst_valid", {31'b0, validInst}, 32'h0);
      checkVal("midrst_rst_reg", {31'b0, rstReg}, 32'h1);

      for (int i = 0; i < 400; i++) begin
         logic r, pe, ie, rd;
         r  = ($urandom_range(0, 60) == 0);
         pe = ($urandom_range(0, 3) != 0);
         ie = ($urandom_range(0, 7) == 0) ? ~pe : pe;
         rd = ($urandom_range(0, 7) == 0);
         applyStimulus(r, pe, ie, rd, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
